// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - burst write-fill / read controller for a single-port synchronous RAM
// Optional power-up clear of the whole RAM: define RAM_ACCESS_CTRL_INIT_CLEAR_EN.
module ram_access_ctrl #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8,
    parameter int SIZE      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    input  logic [3:0]           cmd_len,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 rsp_last,
    output logic                 wr_done,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    input  logic [DATAWIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
        , S_CLEAR
`endif
    } state_t;

`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(SIZE - 1);

    state_t                 state_q, state_d;
    logic [3:0]             left_q, left_d;
    logic                   cs_d, we_d, rv_d, rl_d, done_d;
    logic [ADDRWIDTH-1:0]   addr_d;
    logic [DATAWIDTH-1:0]   wdata_d, rd_d;

    // ram_addr doubles as the beat address; it wraps at the last RAM word.
    function automatic logic [ADDRWIDTH-1:0] next_addr(input logic [ADDRWIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign cmd_ready = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        cs_d    = ram_cs;
        we_d    = ram_we;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        rv_d    = rsp_valid;
        rd_d    = rsp_data;
        rl_d    = rsp_last;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    left_d = cmd_len;
                    addr_d = cmd_addr;
                    cs_d   = 1'b1;
                    if (cmd_we) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        wdata_d = cmd_wdata;
                    end else begin
                        state_d = S_READ;
                        we_d    = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                if (left_q == 4'd0) begin
                    state_d = S_IDLE;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    left_d = left_q - 4'd1;
                    addr_d = next_addr(ram_addr);
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cs_d    = 1'b0;
            end
            S_WAIT: begin
                // The RAM sampled the read at the edge leaving READ; data is valid now.
                state_d = S_RESP;
                rv_d    = 1'b1;
                rd_d    = ram_rdata;
                rl_d    = (left_q == 4'd0);
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rv_d = 1'b0;
                    rl_d = 1'b0;
                    if (rsp_last) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_READ;
                        cs_d    = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = next_addr(ram_addr);
                        left_d  = left_q - 4'd1;
                    end
                end
            end
`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
            S_CLEAR: begin
                // First CLEAR cycle only arms the RAM strobe; then one zero word per cycle.
                wdata_d = '0;
                we_d    = 1'b1;
                if (!ram_cs) begin
                    cs_d   = 1'b1;
                    addr_d = '0;
                end else if (ram_addr == LAST_ADDR) begin
                    state_d = S_IDLE;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    addr_d = next_addr(ram_addr);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b0;
                we_d    = 1'b0;
                rv_d    = 1'b0;
                rl_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            left_q    <= 4'd0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            ram_cs    <= cs_d;
            ram_we    <= we_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            rsp_valid <= rv_d;
            rsp_data  <= rd_d;
            rsp_last  <= rl_d;
            wr_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl with RAM and scoreboard models
module tb_ram_access_ctrl;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b1;
    logic [3:0] cmd_addr = '0, cmd_len = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_last, wr_done, ram_cs, ram_we;
    logic [7:0] rsp_data, ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic [3:0] ram_addr;

    logic [7:0]  mem [N];
    logic [7:0]  smem [N];
    logic [11:0] exp_wr [$];
    logic [3:0]  exp_ra [$];
    logic [8:0]  exp_bt [$];
    logic [8:0]  got_bt [$];
    logic [3:0]  got_wa [$];
    int          exp_done = 0, done_seen = 0;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDRWIDTH(4), .DATAWIDTH(8), .SIZE(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .wr_done(wr_done),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous RAM: write or read sampled at the edge, read data held otherwise.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Scoreboard: every RAM access, response beat and wr_done must match the model queues.
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, pw = 1'b0;
    logic [7:0]  pd = '0;
    logic [11:0] ew;
    logic [8:0]  eb;
    always @(negedge clk) begin
        if (!rst) begin
            check("cs_rsp_exclusive", {31'd0, ram_cs & rsp_valid}, 0);
            if (cmd_ready) check("idle_quiet", {30'd0, ram_cs, rsp_valid}, 0);
            if (ram_cs && ram_we) begin
                got_wa.push_back(ram_addr);
                if (exp_wr.size() == 0) check("unexpected_write", {28'd0, ram_addr}, 32'hFFFF);
                else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", {28'd0, ram_addr}, {28'd0, ew[11:8]});
                    check("wr_data", {24'd0, ram_wdata}, {24'd0, ew[7:0]});
                end
            end
            if (ram_cs && !ram_we) begin
                if (exp_ra.size() == 0) check("unexpected_read", {28'd0, ram_addr}, 32'hFFFF);
                else check("rd_addr", {28'd0, ram_addr}, {28'd0, exp_ra.pop_front()});
            end
            if (wr_done) begin
                done_seen++;
                check("wr_done_expected", {31'd0, exp_done > 0}, 1);
                check("wr_done_after_write", {31'd0, pw}, 1);
                check("wr_done_cs_low", {31'd0, ram_cs}, 0);
                if (exp_done > 0) exp_done--;
            end
            if (pv && !pr) begin
                check("hold_valid", {31'd0, rsp_valid}, 1);
                check("hold_data", {24'd0, rsp_data}, {24'd0, pd});
                check("hold_last", {31'd0, rsp_last}, {31'd0, pl});
            end
            if (rsp_valid && rsp_ready) begin
                got_bt.push_back({rsp_last, rsp_data});
                if (exp_bt.size() == 0) check("unexpected_beat", {23'd0, rsp_last, rsp_data}, 32'hFFFF);
                else begin
                    eb = exp_bt.pop_front();
                    check("beat_data", {24'd0, rsp_data}, {24'd0, eb[7:0]});
                    check("beat_last", {31'd0, rsp_last}, {31'd0, eb[8]});
                end
            end
            pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pl = rsp_last; pw = ram_cs & ram_we;
        end else begin
            pv = 1'b0; pw = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d, input logic [3:0] len);
        int n = 0;
        logic [3:0] ad;
        for (int i = 0; i <= int'(len); i++) begin
            ad = a + i[3:0];
            if (we) begin
                exp_wr.push_back({ad, d});
                smem[ad] = d;
            end else begin
                exp_ra.push_back(ad);
                exp_bt.push_back({i == int'(len), smem[ad]});
            end
        end
        if (we) exp_done++;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_len = len;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        check("accept_timeout", {31'd0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        check("idle_timeout", {31'd0, cmd_ready}, 1);
        tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            mem[i]  = 8'(i * 17);
            smem[i] = 8'(i * 17);
        end
        #12;
        check("rst_outputs", {ram_cs, ram_we, rsp_valid, rsp_last, wr_done, ram_addr, ram_wdata, rsp_data}, 0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, cmd_ready}, 1);

        // Fill 3..5 with A5, then read back with a latency check.
        got_wa.delete();
        issue(1'b1, 4'd3, 8'hA5, 4'd2);
        wait_idle();
        check("t1_wr_count", got_wa.size(), 3);
        if (got_wa.size() == 3) check("t1_wr_addrs", {20'd0, got_wa[0], got_wa[1], got_wa[2]}, 32'h345);
        check("t1_done_count", done_seen, 1);
        got_bt.delete();
        issue(1'b0, 4'd3, 8'h00, 4'd2);
        check("lat_c1", {30'd0, ram_cs, rsp_valid}, 32'b10);
        tick();
        check("lat_c2", {30'd0, ram_cs, rsp_valid}, 32'b00);
        tick();
        check("lat_c3", {31'd0, rsp_valid}, 1);
        wait_idle();
        check("t1_beats", got_bt.size(), 3);
        if (got_bt.size() == 3) check("t1_beat_vals", {5'd0, got_bt[0], got_bt[1], got_bt[2]}, {5'd0, 9'h0A5, 9'h0A5, 9'h1A5});

        // Wrap across the top of the address space.
        got_wa.delete();
        issue(1'b1, 4'd14, 8'h3C, 4'd3);
        wait_idle();
        check("t2_wr_count", got_wa.size(), 4);
        if (got_wa.size() == 4) check("t2_wr_addrs", {16'd0, got_wa[0], got_wa[1], got_wa[2], got_wa[3]}, 32'hEF01);
        got_bt.delete();
        issue(1'b0, 4'd14, 8'h00, 4'd3);
        wait_idle();
        check("t2_beats", got_bt.size(), 4);
        if (got_bt.size() == 4) check("t2_beat_last", {got_bt[0], got_bt[1], got_bt[2], got_bt[3]} == {9'h03C, 9'h03C, 9'h03C, 9'h13C}, 1);

        // Single beat, and a command offered mid-burst that must be ignored.
        issue(1'b1, 4'd15, 8'h77, 4'd0);
        wait_idle();
        issue(1'b1, 4'd6, 8'h5A, 4'd4);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd0; cmd_wdata = 8'hFF; cmd_len = 4'd1;
        tick(); tick(); tick();
        cmd_valid = 1'b0;
        wait_idle();
        check("t3_done_count", done_seen, 4);

        // Backpressure on a single-beat read of an untouched word.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd13, 8'h00, 4'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        for (int c = 0; c < 5; c++) begin
            check("bp_hold", {22'd0, rsp_valid, rsp_last, rsp_data}, {22'd0, 2'b11, 8'hDD});
            check("bp_cs_low", {31'd0, ram_cs}, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", {30'd0, cmd_ready, rsp_valid}, 32'b10);

        // Reset asserted during the second beat of an 8-beat read.
        issue(1'b0, 4'd2, 8'h00, 4'd7);
        n = 0;
        while (!(ram_cs && !ram_we && ram_addr == 4'd3) && n < 20) begin tick(); n++; end
        check("mid_burst_reached", {31'd0, ram_cs}, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_outputs", {ram_cs, ram_we, rsp_valid, rsp_last, wr_done, ram_addr, ram_wdata, rsp_data}, 0);
        exp_ra.delete();
        exp_bt.delete();
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_abort", {29'd0, cmd_ready, rsp_valid, ram_cs}, 32'b100);
        end

        // Full sweep of the RAM against the shadow model.
        got_bt.delete();
        issue(1'b0, 4'd0, 8'h00, 4'd15);
        wait_idle();
        check("sweep_beats", got_bt.size(), 16);
        check("left_wr", exp_wr.size(), 0);
        check("left_rd", exp_ra.size() + exp_bt.size(), 0);
        check("left_done", exp_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_chk);
        $fatal(1);
    end

endmodule
